// File: rtl/sargantana_ifill_responder.sv
// iFill responder: takes one icache line-fill request, reads the line as N_BEATS
// in-order beats from a narrow memory port and returns it as a single-cycle response.
module sargantana_ifill_responder #(
    parameter int LINE_ADDR_W = 34,
    parameter int WAY_W       = 2,
    parameter int LINE_W      = 512,
    parameter int BEAT_W      = 128,
    parameter int N_BEATS     = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   ifill_req_valid_i,
    input  logic [LINE_ADDR_W-1:0]                 ifill_req_paddr_i,
    input  logic [WAY_W-1:0]                       ifill_req_way_i,
    output logic                                   ifill_req_ready_o,
    output logic                                   ifill_resp_ack_o,
    output logic                                   ifill_resp_valid_o,
    output logic [LINE_W-1:0]                      ifill_resp_data_o,
    output logic [WAY_W-1:0]                       ifill_resp_way_o,
    output logic                                   mem_req_valid_o,
    input  logic                                   mem_req_ready_i,
    output logic [LINE_ADDR_W+$clog2(N_BEATS)-1:0] mem_req_addr_o,
    input  logic                                   mem_rsp_valid_i,
    input  logic [BEAT_W-1:0]                      mem_rsp_data_i,
    output logic [31:0]                            fill_count_o
);

    localparam int IDX_W = $clog2(N_BEATS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP,
        DRAIN
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       recv_cnt;
    logic [LINE_ADDR_W-1:0] paddr_q;
    logic [WAY_W-1:0]       way_q;
    logic [LINE_W-1:0]      data_q;
    logic                   ack_q;
    logic [31:0]            fill_cnt_q;

    logic issue_fire;
    logic rsp_take;
    logic last_beat;

    // A response only counts when a beat is actually outstanding; strays are dropped.
    assign mem_req_valid_o = (state == FETCH) && (issue_cnt < CNT_W'(N_BEATS));
    assign issue_fire      = mem_req_valid_o && mem_req_ready_i;
    assign rsp_take        = mem_rsp_valid_i && (recv_cnt != issue_cnt)
                             && ((state == FETCH) || (state == DRAIN));
    assign last_beat       = rsp_take && (recv_cnt == CNT_W'(N_BEATS - 1));

    assign ifill_req_ready_o  = (state == IDLE);
    assign ifill_resp_ack_o   = ack_q;
    assign ifill_resp_valid_o = (state == RESP) && !flush_i;
    assign ifill_resp_data_o  = data_q;
    assign ifill_resp_way_o   = way_q;
    assign mem_req_addr_o     = {paddr_q, issue_cnt[IDX_W-1:0]};
    assign fill_count_o       = fill_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            paddr_q    <= '0;
            way_q      <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            ack_q <= 1'b0;
            if (issue_fire) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (rsp_take) begin
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
            // Beats drained after a flush are counted but never written into the line.
            if (rsp_take && (state == FETCH)) begin
                data_q[int'(recv_cnt[IDX_W-1:0]) * BEAT_W +: BEAT_W] <= mem_rsp_data_i;
            end

            case (state)
                IDLE: begin
                    if (ifill_req_valid_i && !flush_i) begin
                        state     <= FETCH;
                        paddr_q   <= ifill_req_paddr_i;
                        way_q     <= ifill_req_way_i;
                        ack_q     <= 1'b1;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                    end
                end
                FETCH: begin
                    if (flush_i) begin
                        state <= DRAIN;
                    end else if (last_beat) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!flush_i) begin
                        fill_cnt_q <= fill_cnt_q + 32'd1;
                    end
                    state <= IDLE;
                end
                DRAIN: begin
                    if (recv_cnt == issue_cnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rsp_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_rsp_valid_i && (recv_cnt == issue_cnt)));

endmodule
